// File: rtl/layer_input_loader_if.sv
// Stream handshake bundle feeding the layer input loader.
// Upstream drives valid/data/last, loader answers with ready.
interface layer_input_loader_if;
  logic        in_valid;
  logic [63:0] in_data;
  logic        in_last;
  logic        in_ready;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready
  );
endinterface

// File: rtl/layer_input_loader.sv
// Collects a frame of stream words into a parallel array,
// starts the layer and holds the frame until the layer is done.
module layer_input_loader #(
  parameter int INPUTS = 400,
  parameter int CNT_W  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  layer_input_loader_if.slave         s,
  input  logic                        abort,
  output logic [63:0]                 data [INPUTS],
  output logic                        layer_start,
  input  logic                        layer_done,
  output logic                        busy,
  output logic [$clog2(INPUTS)-1:0]   word_idx,
  output logic                        frame_err,
  output logic [CNT_W-1:0]            frames_done
);

  localparam int IDX_W = $clog2(INPUTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INPUTS - 1);

  typedef enum logic [1:0] {
    FILL,
    START,
    BUSY
  } state_t;

  state_t state;
  logic   accept;

  assign s.in_ready = (state == FILL);
  assign busy       = (state != FILL);
  assign accept     = s.in_valid & s.in_ready;

  // Frame fill, layer start pulse and completion tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FILL;
      word_idx    <= '0;
      layer_start <= 1'b0;
      frame_err   <= 1'b0;
      frames_done <= '0;
      for (int i = 0; i < INPUTS; i++) begin
        data[i] <= '0;
      end
    end else begin
      layer_start <= 1'b0;
      frame_err   <= 1'b0;
      unique case (state)
        FILL: begin
          if (abort) begin
            word_idx <= '0;
          end else if (accept) begin
            data[word_idx] <= s.in_data;
            unique case (1'b1)
              (word_idx == LAST_IDX): begin
                word_idx    <= '0;
                state       <= START;
                layer_start <= 1'b1;
                frame_err   <= ~s.in_last;
              end
              (word_idx != LAST_IDX) && s.in_last: begin
                word_idx  <= '0;
                frame_err <= 1'b1;
              end
              default: begin
                word_idx <= word_idx + IDX_W'(1);
              end
            endcase
          end
        end
        START: begin
          state <= BUSY;
        end
        BUSY: begin
          if (layer_done) begin
            frames_done <= frames_done + CNT_W'(1);
            state       <= FILL;
          end
        end
        default: begin
          state <= FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_layer_input_loader.sv
// Directed bench for the layer input loader (4-word frames,
// 2-bit frame counter).
module tb_layer_input_loader;

  localparam int N = 4;

  logic        clk;
  logic        rst;
  logic        abort;
  logic [63:0] data [N];
  logic        layer_start;
  logic        layer_done;
  logic        busy;
  logic [1:0]  word_idx;
  logic        frame_err;
  logic [1:0]  frames_done;

  logic man_done;
  logic model_done;
  logic auto_done;

  int checks;
  int errors;

  layer_input_loader_if sif ();

  layer_input_loader #(
    .INPUTS (N),
    .CNT_W  (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s           (sif.slave),
    .abort       (abort),
    .data        (data),
    .layer_start (layer_start),
    .layer_done  (layer_done),
    .busy        (busy),
    .word_idx    (word_idx),
    .frame_err   (frame_err),
    .frames_done (frames_done)
  );

  assign layer_done = man_done | model_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out", nm);
  endtask

  // Layer model: done pulse ten cycles after a start pulse.
  initial begin
    model_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (auto_done && layer_start) begin
        repeat (9) @(posedge clk);
        #1 model_done = 1'b1;
        @(posedge clk);
        #1 model_done = 1'b0;
      end
    end
  end

  // Frame must not change while it is held for the layer.
  logic [63:0] snap [N];
  bit          was_busy;
  initial was_busy = 1'b0;
  always @(negedge clk) begin
    if (busy && !was_busy) begin
      for (int i = 0; i < N; i++) snap[i] = data[i];
    end else if (busy) begin
      for (int i = 0; i < N; i++) check("data_stable", data[i], snap[i]);
    end
    was_busy = busy;
  end

  typedef struct {
    logic        v;
    logic [63:0] d;
    logic        l;
    logic        ab;
    logic        dn;
    logic        rdy;
    logic [1:0]  idx;
    logic        st;
    logic        err;
    logic        bsy;
    logic [1:0]  fr;
    logic        chk;
    logic [255:0] dat;
  } vec_t;

  vec_t tv [24];

  task automatic put(int row, logic [63:0] d, logic v);
    sif.in_valid = v;
    sif.in_data  = d;
    sif.in_last  = (row == N - 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    auto_done  = 1'b0;
    man_done   = 1'b0;
    abort      = 1'b0;
    sif.in_valid = 1'b0;
    sif.in_data  = '0;
    sif.in_last  = 1'b0;

    tv[0]  = '{1, 1,  0, 0, 0, 1, 1, 0, 0, 0, 0, 0, '0};
    tv[1]  = '{1, 2,  0, 0, 0, 1, 2, 0, 0, 0, 0, 0, '0};
    tv[2]  = '{1, 3,  0, 0, 0, 1, 3, 0, 0, 0, 0, 0, '0};
    tv[3]  = '{1, 4,  1, 0, 0, 0, 0, 1, 0, 1, 0, 0, '0};
    tv[4]  = '{0, 0,  0, 0, 0, 0, 0, 0, 0, 1, 0, 1,
               {64'd4, 64'd3, 64'd2, 64'd1}};
    tv[5]  = '{1, 99, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, '0};
    tv[6]  = '{1, 5,  0, 0, 0, 1, 1, 0, 0, 0, 1, 0, '0};
    tv[7]  = '{1, 6,  1, 0, 0, 1, 0, 0, 1, 0, 1, 0, '0};
    tv[8]  = '{1, 7,  0, 0, 0, 1, 1, 0, 0, 0, 1, 0, '0};
    tv[9]  = '{1, 8,  0, 0, 0, 1, 2, 0, 0, 0, 1, 0, '0};
    tv[10] = '{1, 9,  0, 0, 0, 1, 3, 0, 0, 0, 1, 0, '0};
    tv[11] = '{1, 10, 1, 0, 0, 0, 0, 1, 0, 1, 1, 0, '0};
    tv[12] = '{0, 0,  0, 1, 0, 0, 0, 0, 0, 1, 1, 1,
               {64'd10, 64'd9, 64'd8, 64'd7}};
    tv[13] = '{0, 0,  0, 0, 1, 1, 0, 0, 0, 0, 2, 0, '0};
    tv[14] = '{1, 11, 0, 0, 0, 1, 1, 0, 0, 0, 2, 0, '0};
    tv[15] = '{1, 12, 0, 0, 0, 1, 2, 0, 0, 0, 2, 0, '0};
    tv[16] = '{1, 13, 0, 0, 0, 1, 3, 0, 0, 0, 2, 0, '0};
    tv[17] = '{1, 14, 0, 0, 0, 0, 0, 1, 1, 1, 2, 0, '0};
    tv[18] = '{0, 0,  0, 0, 0, 0, 0, 0, 0, 1, 2, 1,
               {64'd14, 64'd13, 64'd12, 64'd11}};
    tv[19] = '{0, 0,  0, 0, 1, 1, 0, 0, 0, 0, 3, 0, '0};
    tv[20] = '{1, 21, 0, 0, 0, 1, 1, 0, 0, 0, 3, 0, '0};
    tv[21] = '{1, 22, 0, 0, 0, 1, 2, 0, 0, 0, 3, 0, '0};
    tv[22] = '{1, 23, 0, 1, 0, 1, 0, 0, 0, 0, 3, 0, '0};
    tv[23] = '{0, 0,  0, 0, 1, 1, 0, 0, 0, 0, 3, 1,
               {64'd14, 64'd13, 64'd22, 64'd21}};

    // reset state
    rst = 1'b1;
    #12;
    check("rst_start", layer_start, 0);
    check("rst_err", frame_err, 0);
    check("rst_busy", busy, 0);
    check("rst_idx", word_idx, 0);
    check("rst_frames", frames_done, 0);
    check("rst_data", data[0], 0);
    @(negedge clk);
    #1 rst = 1'b0;
    #1 check("rst_ready", sif.in_ready, 1);
    @(posedge clk);
    #1;

    // directed vector table
    for (int i = 0; i < 24; i++) begin
      sif.in_valid = tv[i].v;
      sif.in_data  = tv[i].d;
      sif.in_last  = tv[i].l;
      abort        = tv[i].ab;
      man_done     = tv[i].dn;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_ready", i), sif.in_ready, tv[i].rdy);
      check($sformatf("v%0d_idx", i), word_idx, tv[i].idx);
      check($sformatf("v%0d_start", i), layer_start, tv[i].st);
      check($sformatf("v%0d_err", i), frame_err, tv[i].err);
      check($sformatf("v%0d_busy", i), busy, tv[i].bsy);
      check($sformatf("v%0d_frames", i), frames_done, tv[i].fr);
      if (tv[i].chk) begin
        for (int k = 0; k < N; k++)
          check($sformatf("v%0d_data%0d", i, k), data[k],
                tv[i].dat[k*64 +: 64]);
      end
    end
    sif.in_valid = 1'b0;
    abort        = 1'b0;
    man_done     = 1'b0;

    // reset while holding a frame
    for (int i = 0; i < N; i++) put(i, 64'h50 + 64'(i), 1'b1);
    sif.in_valid = 1'b0;
    @(posedge clk);
    #1 check("rb_busy_before", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("rb_busy", busy, 0);
    check("rb_ready", sif.in_ready, 1);
    check("rb_idx", word_idx, 0);
    check("rb_frames", frames_done, 0);
    check("rb_start", layer_start, 0);
    check("rb_data3", data[3], 0);
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // continuous offer through a layer run
    auto_done = 1'b1;
    for (int i = 0; i < N; i++) put(i, 64'h100 + 64'(i), 1'b1);
    check("c_start", layer_start, 1);
    sif.in_data = 64'h999;
    sif.in_last = 1'b0;
    begin
      int cyc;
      cyc = 0;
      while (frames_done == 2'd0 && cyc < 40) begin
        @(posedge clk);
        #1;
        if (frames_done == 2'd0) check("c_ready_low", sif.in_ready, 0);
        cyc++;
      end
      if (cyc >= 40) timeout("c_done");
      check("c_done_cycle", 64'(cyc), 10);
    end
    check("c_ready_up", sif.in_ready, 1);
    check("c_idx_done", word_idx, 0);
    @(posedge clk);
    #1;
    check("c_idx_next", word_idx, 1);
    check("c_data0", data[0], 64'h999);
    sif.in_valid = 1'b0;
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("c_abort_idx", word_idx, 0);

    // five frames with random gaps, counter wraps
    rst = 1'b1;
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    for (int f = 0; f < 5; f++) begin
      for (int w = 0; w < N; w++) begin
        int t;
        sif.in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
        t = 0;
        while (!sif.in_ready && t < 50) begin
          @(posedge clk);
          #1;
          t++;
        end
        if (t >= 50) timeout("g_ready");
        put(w, 64'(f * 16 + w), 1'b1);
      end
      sif.in_valid = 1'b0;
    end
    begin
      int t;
      t = 0;
      while (busy && t < 50) begin
        @(posedge clk);
        #1;
        t++;
      end
      if (t >= 50) timeout("g_idle");
    end
    check("g_frames_wrap", frames_done, 1);
    for (int k = 0; k < N; k++)
      check($sformatf("g_data%0d", k), data[k], 64'(64 + k));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
